pulse_transmitter_job_scheduler: RTL and testbench

PULSE_TRANSMITTER_JOB_SCHEDULER -- requirements
Module: pulse_transmitter_job_scheduler

---
 rtl/pulse_transmitter_job_scheduler.sv | 148 ++++++++++++++
 tb/tb_pulse_transmitter_job_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_transmitter_job_scheduler.sv
// rtl/pulse_transmitter_job_scheduler.sv - queued job scheduler driving a pulse transmitter
// Purpose: buffers job descriptors in a small FIFO and sequences them onto the
//    transmitter (IDLE -> LOAD -> ARM -> RUN -> GAP), with arm timeout and abort.
// Ports:
//    clk, rst                  clock, asynchronous active-high reset
//    en, abort                 scheduler enable, queue flush / job stop
//    push_valid/data/ready     job descriptor input
//    gap_cycles                idle cycles inserted after each job
//    tx_busy                   transmitter activity
//    tx_start, tx_*            transmitter start level and job fields
//    job_done, arm_error       completion / arm-timeout pulses
//    queue_level, idle         queue occupancy, scheduler quiescent
module pulse_transmitter_job_scheduler #(
   parameter int FIFO_DEPTH  = 4,
   parameter int GAP_WIDTH   = 16,
   parameter int ARM_TIMEOUT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          abort,
   input  logic                          push_valid,
   input  logic [25:0]                   push_data,
   output logic                          push_ready,
   input  logic [GAP_WIDTH-1:0]          gap_cycles,
   input  logic                          tx_busy,
   output logic                          tx_start,
   output logic [6:0]                    tx_start_index,
   output logic [6:0]                    tx_end_index,
   output logic [7:0]                    tx_loop_count,
   output logic [3:0]                    tx_prescaler,
   output logic                          job_done,
   output logic                          arm_error,
   output logic [$clog2(FIFO_DEPTH):0]   queue_level,
   output logic                          idle
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = $clog2(ARM_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, GAP} state_t;

   state_t               state;
   logic [25:0]          mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic [GAP_WIDTH-1:0] gap_cnt;
   logic [AW-1:0]        arm_timer;
   logic                 push;
   logic                 pop;

   // Readiness comes from the registered count only, so a pop in the same
   // cycle never makes room for a push while full.
   assign push_ready  = (count < CW'(FIFO_DEPTH));
   assign push        = push_valid && push_ready && !abort;
   assign pop         = (state == LOAD);
   assign queue_level = count;
   assign idle        = (state == IDLE) && (count == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         gap_cnt        <= '0;
         arm_timer      <= '0;
         tx_start       <= 1'b0;
         tx_start_index <= '0;
         tx_end_index   <= '0;
         tx_loop_count  <= '0;
         tx_prescaler   <= '0;
         job_done       <= 1'b0;
         arm_error      <= 1'b0;
      end else if (abort) begin
         // Flush and stop; job fields are left as they were.
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         gap_cnt   <= '0;
         arm_timer <= '0;
         tx_start  <= 1'b0;
         job_done  <= 1'b0;
         arm_error <= 1'b0;
      end else begin
         job_done  <= 1'b0;
         arm_error <= 1'b0;

         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);

         case (state)
            IDLE: begin
               tx_start <= 1'b0;
               if (en && count != '0) state <= LOAD;
            end
            LOAD: begin
               tx_start_index <= mem[rd_ptr][6:0];
               tx_end_index   <= mem[rd_ptr][13:7];
               tx_loop_count  <= mem[rd_ptr][21:14];
               tx_prescaler   <= mem[rd_ptr][25:22];
               tx_start       <= 1'b1;
               arm_timer      <= AW'(1);
               state          <= ARM;
            end
            ARM: begin
               if (tx_busy) begin
                  state <= RUN;
               end else if (arm_timer == AW'(ARM_TIMEOUT)) begin
                  tx_start  <= 1'b0;
                  arm_error <= 1'b1;
                  gap_cnt   <= gap_cycles;
                  state     <= GAP;
               end else begin
                  arm_timer <= arm_timer + AW'(1);
               end
            end
            RUN: begin
               if (!tx_busy) begin
                  tx_start <= 1'b0;
                  job_done <= 1'b1;
                  gap_cnt  <= gap_cycles;
                  state    <= GAP;
               end
            end
            GAP: begin
               // Counter reaching zero costs one more cycle, so gap_cycles=N
               // yields N+1 GAP cycles.
               if (gap_cnt == '0) state   <= IDLE;
               else               gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_transmitter_job_scheduler.sv
// tb/tb_pulse_transmitter_job_scheduler.sv - self-checking bench for the job scheduler
module tb_pulse_transmitter_job_scheduler;

   localparam int FIFO_DEPTH  = 4;
   localparam int GAP_WIDTH   = 16;
   localparam int ARM_TIMEOUT = 4;
   localparam int LW          = $clog2(FIFO_DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 abort;
   logic                 push_valid;
   logic [25:0]          push_data;
   logic                 push_ready;
   logic [GAP_WIDTH-1:0] gap_cycles;
   logic                 tx_busy;
   logic                 tx_start;
   logic [6:0]           tx_start_index;
   logic [6:0]           tx_end_index;
   logic [7:0]           tx_loop_count;
   logic [3:0]           tx_prescaler;
   logic                 job_done;
   logic                 arm_error;
   logic [LW-1:0]        queue_level;
   logic                 idle;

   always #5 clk = ~clk;

   pulse_transmitter_job_scheduler #(
      .FIFO_DEPTH(FIFO_DEPTH), .GAP_WIDTH(GAP_WIDTH), .ARM_TIMEOUT(ARM_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .abort(abort),
      .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
      .gap_cycles(gap_cycles), .tx_busy(tx_busy), .tx_start(tx_start),
      .tx_start_index(tx_start_index), .tx_end_index(tx_end_index),
      .tx_loop_count(tx_loop_count), .tx_prescaler(tx_prescaler),
      .job_done(job_done), .arm_error(arm_error),
      .queue_level(queue_level), .idle(idle)
   );

   typedef struct {
      logic          pv;
      logic [25:0]   data;
      logic          acc;
      logic [LW-1:0] lvl;
      logic          rdy;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [25:0] exp_q[$];
   int          tx_mode;
   int          busy_len;
   int          tx_cnt;
   logic        prev_start;
   int          done_cnt, err_cnt, rises;
   int          high_run, last_high, low_run, last_low;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic logic [25:0] job(input int s, input int e, input int l, input int p);
      return {p[3:0], l[7:0], e[6:0], s[6:0]};
   endfunction

   // One clock: sample outputs 1ns after the edge, update scoreboard and
   // run the transmitter model (busy from 2 samples after start, busy_len long).
   task automatic step();
      logic [25:0] e;
      @(posedge clk);
      #1;
      if (job_done)  done_cnt++;
      if (arm_error) err_cnt++;
      if (tx_start && !prev_start) begin
         rises++;
         last_low = low_run;
         low_run  = 0;
         high_run = 0;
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 1);
         end else begin
            e = exp_q.pop_front();
            chk("job_fields", 32'({tx_prescaler, tx_loop_count, tx_end_index, tx_start_index}), 32'(e));
         end
      end
      if (tx_start) high_run++;
      else begin
         if (prev_start) last_high = high_run;
         low_run++;
      end
      prev_start = tx_start;
      if (tx_start) tx_cnt++;
      else          tx_cnt = 0;
      tx_busy = (tx_mode == 1) && (tx_cnt >= 2) && (tx_cnt < 2 + busy_len);
   endtask

   task automatic push_job(input logic [25:0] d);
      push_valid = 1'b1;
      push_data  = d;
      exp_q.push_back(d);
      step();
      push_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         step();
         n++;
      end
      chk(name, 32'(done_cnt), 32'(target));
   endtask

   initial begin
      vec_t vt[6];
      int   n, r0, base, g;

      rst = 1'b1; en = 1'b0; abort = 1'b0; push_valid = 1'b0; push_data = '0;
      gap_cycles = '0; tx_busy = 1'b0; tx_mode = 1; busy_len = 3; tx_cnt = 0;
      prev_start = 1'b0; done_cnt = 0; err_cnt = 0; rises = 0;
      high_run = 0; last_high = 0; low_run = 0; last_low = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_fields", 32'({tx_prescaler, tx_loop_count, tx_end_index, tx_start_index}), 0);
      chk("rst_level", 32'(queue_level), 0);
      chk("rst_ready", 32'(push_ready), 1);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_pulses", 32'({job_done, arm_error}), 0);
      rst = 1'b0;
      step();

      // Fill with en=0: four accepted, fifth refused at full.
      vt[0] = '{1'b1, job(1, 10, 2, 1), 1'b1, LW'(1), 1'b1};
      vt[1] = '{1'b1, job(3, 20, 4, 2), 1'b1, LW'(2), 1'b1};
      vt[2] = '{1'b1, job(5, 30, 6, 3), 1'b1, LW'(3), 1'b1};
      vt[3] = '{1'b1, job(7, 40, 8, 4), 1'b1, LW'(4), 1'b0};
      vt[4] = '{1'b1, job(9, 50, 9, 6), 1'b0, LW'(4), 1'b0};
      vt[5] = '{1'b0, 26'd0,            1'b0, LW'(4), 1'b0};
      for (int i = 0; i < 6; i++) begin
         push_valid = vt[i].pv;
         push_data  = vt[i].data;
         if (vt[i].pv && vt[i].acc) exp_q.push_back(vt[i].data);
         step();
         chk($sformatf("vec%0d_level", i), 32'(queue_level), 32'(vt[i].lvl));
         chk($sformatf("vec%0d_ready", i), 32'(push_ready), 32'(vt[i].rdy));
      end
      push_valid = 1'b0;
      chk("full_not_idle", 32'(idle), 0);

      // Drain in push order; gap_cycles=0 gives 3 low cycles between jobs.
      en = 1'b1; done_cnt = 0; base = rises; n = 0;
      while (done_cnt < 4 && n < 300) begin
         r0 = rises;
         step();
         if (rises != r0 && rises > base + 1) chk("min_low_gap", 32'(last_low), 3);
         n++;
      end
      chk("drain_done", 32'(done_cnt), 4);
      repeat (3) step();
      chk("drain_sb_empty", 32'(exp_q.size()), 0);
      chk("drain_idle", 32'(idle), 1);

      // Single job, 20 busy cycles, gap 5.
      gap_cycles = 16'd5; busy_len = 20; done_cnt = 0;
      push_job(job(2, 9, 3, 5));
      wait_done(1, 100, "single_done");
      chk("single_high_time", 32'(last_high), 22);
      chk("single_start_low", 32'(tx_start), 0);
      g = 0;
      while (!idle && g < 20) begin
         g++;
         step();
      end
      chk("gap5_cycles", 32'(g), 6);
      chk("single_fields_hold", 32'({tx_prescaler, tx_loop_count, tx_end_index, tx_start_index}),
          32'(job(2, 9, 3, 5)));
      chk("single_one_done", 32'(done_cnt), 1);

      // Arm timeout, then the next job runs normally.
      tx_mode = 0; gap_cycles = '0; busy_len = 2; err_cnt = 0; done_cnt = 0;
      push_job(job(11, 12, 1, 7));
      push_job(job(13, 14, 2, 8));
      n = 0;
      while (err_cnt < 1 && n < 50) begin
         step();
         n++;
      end
      chk("arm_error_seen", 32'(err_cnt), 1);
      chk("arm_high_cycles", 32'(last_high), ARM_TIMEOUT);
      chk("arm_start_low", 32'(tx_start), 0);
      tx_mode = 1;
      wait_done(1, 100, "after_arm_done");
      chk("arm_error_once", 32'(err_cnt), 1);
      repeat (4) step();

      // Abort during RUN with three queued; simultaneous push is discarded.
      en = 1'b0; busy_len = 20;
      push_job(job(20, 21, 1, 1));
      push_job(job(22, 23, 2, 2));
      push_job(job(24, 25, 3, 3));
      push_job(job(26, 27, 4, 4));
      en = 1'b1; n = 0;
      while (!tx_busy && n < 20) begin
         step();
         n++;
      end
      chk("abort_busy_seen", 32'(tx_busy), 1);
      step();
      step();
      chk("pre_abort_level", 32'(queue_level), 3);
      done_cnt = 0;
      abort = 1'b1; push_valid = 1'b1; push_data = job(30, 31, 5, 5);
      step();
      abort = 1'b0; push_valid = 1'b0;
      chk("abort_tx_start", 32'(tx_start), 0);
      chk("abort_level", 32'(queue_level), 0);
      chk("abort_idle", 32'(idle), 1);
      chk("abort_no_done_pulse", 32'(job_done), 0);
      exp_q.delete();
      repeat (10) step();
      chk("abort_no_done", 32'(done_cnt), 0);
      chk("abort_stays_idle", 32'(idle), 1);

      // Push coinciding with the LOAD pop at level 2; pointers wrap.
      en = 1'b0; busy_len = 2; gap_cycles = 16'd1;
      push_job(job(40, 41, 1, 9));
      push_job(job(42, 43, 2, 10));
      chk("pp_level_before", 32'(queue_level), 2);
      en = 1'b1;
      step();
      push_job(job(44, 45, 3, 11));
      chk("push_pop_level", 32'(queue_level), 2);
      push_job(job(46, 47, 4, 12));
      push_job(job(48, 49, 5, 13));
      chk("pp_level_full", 32'(queue_level), 4);
      done_cnt = 0;
      wait_done(5, 400, "wrap_done");
      chk("wrap_sb_empty", 32'(exp_q.size()), 0);
      repeat (4) step();

      // Asynchronous reset mid-GAP with two queued.
      en = 1'b0; gap_cycles = 16'd10;
      push_job(job(50, 51, 1, 1));
      push_job(job(52, 53, 2, 2));
      push_job(job(54, 55, 3, 3));
      en = 1'b1; done_cnt = 0;
      wait_done(1, 100, "pre_rst_done");
      step();
      step();
      chk("pre_rst_level", 32'(queue_level), 2);
      chk("pre_rst_not_idle", 32'(idle), 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_tx_start", 32'(tx_start), 0);
      chk("arst_fields", 32'({tx_prescaler, tx_loop_count, tx_end_index, tx_start_index}), 0);
      chk("arst_level", 32'(queue_level), 0);
      chk("arst_ready", 32'(push_ready), 1);
      chk("arst_idle", 32'(idle), 1);
      chk("arst_pulses", 32'({job_done, arm_error}), 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (3) step();
      chk("post_rst_idle", 32'(idle), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
